forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
//  Parametrised operand forwarding and load-use hazard unit for the MIPS pipeline.
//  Compares N_OPERANDS decode-stage source registers against N_STAGES downstream
//  write-back destinations. Registers the selects into EX and muxes the forwarded
//  data. Raises a same-cycle stall when the matching producer is not yet ready.
//  Never forwards register 0, and counts stall cycles for performance debug.
// PARAMETERS
//  NB_REG_ADDR  5   register address width
//  NB_REG       32  data width
//  N_OPERANDS   2   number of source operands checked (rs, rt, ...)
//  N_STAGES     3   forwarding sources; index 0 = youngest (EX), rising = older
//  NB_CNT       16  stall counter width
//  NB_SEL       = $clog2(N_STAGES>1 ? N_STAGES : 2), derived localparam
// PORTS
//  i_clock        in   1                    clock, rising edge
//  i_reset        in   1                    asynchronous reset, active-low
//  i_valid        in   1                    pipeline advance enable
//  i_flush        in   1                    kill instruction entering EX
//  i_clear_cnt    in   1                    synchronous clear of stall counter
//  i_rs           in   N_OPERANDS*NB_REG_ADDR  decode source regs, operand j at [j*NB_REG_ADDR +: NB_REG_ADDR]
//  i_use          in   N_OPERANDS           operand j really read by the instruction
//  i_we           in   N_STAGES             stage k writes a register
//  i_rd           in   N_STAGES*NB_REG_ADDR destination reg of stage k
//  i_ready        in   N_STAGES             stage k result available (0 = load in flight)
//  i_data         in   N_STAGES*NB_REG      pipeline-latch data of stage k
//  o_fwd_en       out  N_OPERANDS           registered: EX operand j takes forwarded data
//  o_fwd_sel      out  N_OPERANDS*NB_SEL    registered: source stage per operand
//  o_data         out  N_OPERANDS*NB_REG    forwarded data per operand
//  o_stall        out  1                    combinational: hold fetch/decode this cycle
//  o_stall_cycles out  NB_CNT               saturating count of stalled cycles
// BEHAVIOUR
//  Match (combinational, decode cycle):
//   m[j][k] = i_use[j] & i_we[k] & (rs_j == rd_k) & (rs_j != 0).
//   hit_j = OR over k of m[j][k]. src_j = lowest k with m[j][k] (youngest wins).
//   haz_j = hit_j & ~i_ready[src_j]. o_stall = i_valid & OR_j haz_j.
//   Only the youngest matching stage is considered: an older ready stage never
//   masks a younger non-ready one.
//  Registered state: fwd_en[j], sel[j], stall counter. Update priority per edge:
//   1. i_reset low: fwd_en=0, sel=0, cnt=0. Takes effect immediately (async).
//   2. i_valid=0: all state holds. Counter holds, no increment.
//   3. i_flush=1: fwd_en<=0, sel holds. Flush outranks stall.
//   4. o_stall=1: fwd_en<=0 (bubble into EX), sel holds.
//   5. Otherwise: fwd_en[j]<=hit_j, sel[j]<=src_j.
//  Counter: with i_clear_cnt=1 -> cnt<=0, and clear wins over increment.
//   Otherwise, when o_stall=1 -> cnt<=cnt+1, saturating at all-ones (no wrap).
//  Data, combinational from registered selects:
//   o_data[j] = fwd_en[j] ? i_data[sel[j]] : 0.
//   Latency: match in cycle N is used with producer data in cycle N+1.
//  A stalled instruction re-evaluates every cycle until the producer is ready.
//   No internal stall state beyond fwd_en.
//  Reset values: o_fwd_en=0, o_fwd_sel=0, o_data=0, o_stall_cycles=0.
//   o_stall follows its inputs, even during reset.
//  N_STAGES=1 is legal: sel is 1 bit and always 0.
// TESTING
//  1. rs=5, EX rd=5 we=1 ready=1, i_data[0]=0xAAAA0001 -> next cycle
//     o_fwd_en[0]=1, sel=0, o_data[0]=0xAAAA0001, o_stall=0.
//  2. rs=7 matching EX (ready) and MEM rd=7 -> EX selected, sel=0.
//     Repeat with only MEM matching -> sel=1.
//  3. rt=9, EX rd=9 we=1 ready=0 -> o_stall=1 same cycle, next o_fwd_en=0, cnt=1.
//     Then ready=1 -> stall drops, o_fwd_en[1]=1.
//  4. rs=0, EX rd=0 we=1 -> no forward, no stall. i_use=0 with a match -> no forward.
//  5. Matching state with i_valid=0 -> o_fwd_en/sel/cnt unchanged.
//     i_flush=1 with hazard -> o_fwd_en=0, counter still increments.
//  6. Force 2^NB_CNT+3 stall cycles -> cnt saturates at all-ones. i_clear_cnt -> 0.
//     i_reset low mid-stall -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/forwarding_hazard_unit_if.sv
// Decode-to-EX forwarding bus: source/destination compares in, selects and data out.
interface forwarding_hazard_unit_if #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_REG      = 32,
    parameter int N_OPERANDS  = 2,
    parameter int N_STAGES    = 3,
    parameter int NB_CNT      = 16
);
    localparam int NB_SEL = $clog2(N_STAGES > 1 ? N_STAGES : 2);

    logic                              i_valid;
    logic                              i_flush;
    logic                              i_clear_cnt;
    logic [N_OPERANDS*NB_REG_ADDR-1:0] i_rs;
    logic [N_OPERANDS-1:0]             i_use;
    logic [N_STAGES-1:0]               i_we;
    logic [N_STAGES*NB_REG_ADDR-1:0]   i_rd;
    logic [N_STAGES-1:0]               i_ready;
    logic [N_STAGES*NB_REG-1:0]        i_data;
    logic [N_OPERANDS-1:0]             o_fwd_en;
    logic [N_OPERANDS*NB_SEL-1:0]      o_fwd_sel;
    logic [N_OPERANDS*NB_REG-1:0]      o_data;
    logic                              o_stall;
    logic [NB_CNT-1:0]                 o_stall_cycles;

    modport master (
        output i_valid, i_flush, i_clear_cnt, i_rs, i_use,
        output i_we, i_rd, i_ready, i_data,
        input  o_fwd_en, o_fwd_sel, o_data, o_stall, o_stall_cycles
    );

    modport slave (
        input  i_valid, i_flush, i_clear_cnt, i_rs, i_use,
        input  i_we, i_rd, i_ready, i_data,
        output o_fwd_en, o_fwd_sel, o_data, o_stall, o_stall_cycles
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the pipeline.
// Youngest matching producer wins; not-ready producer raises a same-cycle stall.
module forwarding_hazard_unit #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_REG      = 32,
    parameter int N_OPERANDS  = 2,
    parameter int N_STAGES    = 3,
    parameter int NB_CNT      = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    forwarding_hazard_unit_if.slave bus
);
    localparam int NB_SEL = $clog2(N_STAGES > 1 ? N_STAGES : 2);
    localparam logic [NB_CNT-1:0] CNT_MAX = '1;

    logic [N_OPERANDS-1:0]             hit;
    logic [N_OPERANDS-1:0]             haz;
    logic [N_OPERANDS-1:0][NB_SEL-1:0] src;
    logic [N_OPERANDS-1:0]             fwd_en;
    logic [N_OPERANDS-1:0][NB_SEL-1:0] sel;
    logic [N_OPERANDS*NB_REG-1:0]      data;
    logic [NB_CNT-1:0]                 cnt;
    logic                              stall;

    // Scan oldest to youngest so the lowest matching index is left in src.
    always_comb begin
        hit = '0;
        haz = '0;
        src = '0;
        for (int j = 0; j < N_OPERANDS; j++) begin
            for (int k = N_STAGES - 1; k >= 0; k--) begin
                if (bus.i_use[j] && bus.i_we[k] &&
                    bus.i_rs[j*NB_REG_ADDR +: NB_REG_ADDR] ==
                    bus.i_rd[k*NB_REG_ADDR +: NB_REG_ADDR] &&
                    bus.i_rs[j*NB_REG_ADDR +: NB_REG_ADDR] != '0) begin
                    hit[j] = 1'b1;
                    src[j] = NB_SEL'(k);
                end
            end
            haz[j] = hit[j] & ~bus.i_ready[src[j]];
        end
    end

    assign stall = bus.i_valid & (|haz);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            fwd_en <= '0;
            sel    <= '0;
            cnt    <= '0;
        end else if (bus.i_valid) begin
            if (bus.i_flush || stall) begin
                fwd_en <= '0;
            end else begin
                fwd_en <= hit;
                sel    <= src;
            end
            if (bus.i_clear_cnt) begin
                cnt <= '0;
            end else if (stall && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        data = '0;
        for (int j = 0; j < N_OPERANDS; j++) begin
            if (fwd_en[j]) begin
                data[j*NB_REG +: NB_REG] =
                    bus.i_data[int'(sel[j])*NB_REG +: NB_REG];
            end
        end
    end

    assign bus.o_fwd_en       = fwd_en;
    assign bus.o_fwd_sel      = sel;
    assign bus.o_data         = data;
    assign bus.o_stall        = stall;
    assign bus.o_stall_cycles = cnt;
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit with a list-based reference model.
module tb_forwarding_hazard_unit;
    localparam int NA   = 5;
    localparam int NR   = 32;
    localparam int NO   = 2;
    localparam int NS   = 3;
    localparam int NC   = 8;
    localparam int NSEL = 2;
    localparam int CMAX = (1 << NC) - 1;

    typedef struct {
        bit              stall;
        bit [NO-1:0]     en;
        bit [NO*NSEL-1:0] sel;
        bit [NO*NR-1:0]  data;
        int              cnt;
        string           tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    forwarding_hazard_unit_if #(
        .NB_REG_ADDR(NA), .NB_REG(NR), .N_OPERANDS(NO),
        .N_STAGES(NS), .NB_CNT(NC)
    ) bus ();

    forwarding_hazard_unit #(
        .NB_REG_ADDR(NA), .NB_REG(NR), .N_OPERANDS(NO),
        .N_STAGES(NS), .NB_CNT(NC)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t sbq[$];
    event chk;

    int        rs[NO];
    bit        use_op[NO];
    bit        we[NS];
    int        rd[NS];
    bit        rdy[NS];
    bit [31:0] dat[NS];
    bit        valid, flush, clr;

    int m_en[NO];
    int m_sel[NO];
    int m_cnt;
    bit e_hit[NO];
    int e_src[NO];
    bit e_stall;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.i_valid     = valid;
        bus.i_flush     = flush;
        bus.i_clear_cnt = clr;
        for (int j = 0; j < NO; j++) begin
            bus.i_rs[j*NA +: NA] = NA'(rs[j]);
            bus.i_use[j]         = use_op[j];
        end
        for (int k = 0; k < NS; k++) begin
            bus.i_we[k]          = we[k];
            bus.i_rd[k*NA +: NA] = NA'(rd[k]);
            bus.i_ready[k]       = rdy[k];
            bus.i_data[k*NR +: NR] = dat[k];
        end
    endtask

    // Collect every producer writing the operand; the front of the list is the youngest.
    function automatic void model_eval();
        e_stall = 1'b0;
        for (int j = 0; j < NO; j++) begin
            int q[$];
            for (int k = 0; k < NS; k++)
                if (use_op[j] && we[k] && rs[j] == rd[k] && rs[j] != 0)
                    q.push_back(k);
            e_hit[j] = q.size() > 0;
            e_src[j] = e_hit[j] ? q[0] : 0;
            if (e_hit[j] && !rdy[e_src[j]] && valid) e_stall = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < NO; j++) begin
            m_en[j]  = 0;
            m_sel[j] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_clock();
        model_eval();
        if (!valid) return;
        for (int j = 0; j < NO; j++) begin
            if (flush || e_stall) begin
                m_en[j] = 0;
            end else begin
                m_en[j]  = e_hit[j];
                m_sel[j] = e_src[j];
            end
        end
        if (clr) m_cnt = 0;
        else if (e_stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
    endfunction

    task automatic issue(string tag);
        exp_t e;
        drive();
        #1;
        model_eval();
        e.stall = e_stall;
        e.en = '0;
        e.sel = '0;
        e.data = '0;
        for (int j = 0; j < NO; j++) begin
            e.en[j] = m_en[j] != 0;
            e.sel[j*NSEL +: NSEL] = NSEL'(m_sel[j]);
            if (m_en[j] != 0) e.data[j*NR +: NR] = dat[m_sel[j]];
        end
        e.cnt = m_cnt;
        e.tag = tag;
        sbq.push_back(e);
        ->chk;
    endtask

    task automatic cycle(string tag);
        issue(tag);
        @(posedge clk);
        if (rst_n) model_clock();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int j = 0; j < NO; j++) begin
            rs[j] = 0;
            use_op[j] = 1'b0;
        end
        for (int k = 0; k < NS; k++) begin
            we[k]  = 1'b0;
            rd[k]  = 0;
            rdy[k] = 1'b1;
            dat[k] = $urandom;
        end
        valid = 1'b1;
        flush = 1'b0;
        clr   = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got no expectation required one");
            end else begin
                e = sbq.pop_front();
                check({e.tag, ".stall"}, 64'(bus.o_stall), 64'(e.stall));
                check({e.tag, ".en"}, 64'(bus.o_fwd_en), 64'(e.en));
                check({e.tag, ".sel"}, 64'(bus.o_fwd_sel), 64'(e.sel));
                check({e.tag, ".data"}, 64'(bus.o_data), 64'(e.data));
                check({e.tag, ".cnt"}, 64'(bus.o_stall_cycles), 64'(e.cnt));
            end
        end
    end

    initial begin : stim
        model_reset();
        idle_inputs();
        drive();
        @(negedge clk);
        cycle("reset");
        rst_n = 1'b1;
        cycle("idle");

        // Basic EX forward
        rs[0] = 5; use_op[0] = 1; we[0] = 1; rd[0] = 5; dat[0] = 32'hAAAA0001;
        cycle("t1a");
        check("t1.en", 64'(bus.o_fwd_en[0]), 64'd1);
        check("t1.data", 64'(bus.o_data[31:0]), 64'hAAAA0001);
        issue("t1b");
        @(posedge clk); model_clock(); @(negedge clk);

        // Youngest wins, then older-only
        idle_inputs();
        rs[0] = 7; use_op[0] = 1; we[0] = 1; rd[0] = 7; we[1] = 1; rd[1] = 7;
        cycle("t2a");
        check("t2.sel_ex", 64'(bus.o_fwd_sel[1:0]), 64'd0);
        we[0] = 0;
        cycle("t2b");
        check("t2.sel_mem", 64'(bus.o_fwd_sel[1:0]), 64'd1);

        // Load-use stall on rt, then release
        idle_inputs();
        rs[1] = 9; use_op[1] = 1; we[0] = 1; rd[0] = 9; rdy[0] = 0;
        cycle("t3a");
        check("t3.en_bubble", 64'(bus.o_fwd_en[1]), 64'd0);
        check("t3.cnt", 64'(bus.o_stall_cycles), 64'd1);
        rdy[0] = 1;
        cycle("t3b");
        check("t3.en_fwd", 64'(bus.o_fwd_en[1]), 64'd1);

        // Register 0 and unused operand
        idle_inputs();
        rs[0] = 0; use_op[0] = 1; we[0] = 1; rd[0] = 0;
        cycle("t4a");
        rs[0] = 3; rd[0] = 3; use_op[0] = 0;
        cycle("t4b");
        check("t4.en", 64'(bus.o_fwd_en), 64'd0);

        // Hold on invalid, flush with hazard
        idle_inputs();
        rs[0] = 4; use_op[0] = 1; we[2] = 1; rd[2] = 4;
        cycle("t5a");
        valid = 0; rd[2] = 6; rdy[2] = 0; rs[1] = 6; use_op[1] = 1;
        cycle("t5b");
        valid = 1; flush = 1; rd[2] = 4;
        cycle("t5c");
        flush = 0;
        cycle("t5d");

        // Saturation, clear, async reset
        idle_inputs();
        rs[0] = 12; use_op[0] = 1; we[1] = 1; rd[1] = 12; rdy[1] = 0;
        for (int i = 0; i < (1 << NC) + 3; i++) cycle("t6sat");
        check("t6.sat", 64'(bus.o_stall_cycles), 64'(CMAX));
        clr = 1;
        cycle("t6clr");
        check("t6.clr", 64'(bus.o_stall_cycles), 64'd0);
        clr = 0;
        repeat (3) cycle("t6run");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6.rst_en", 64'(bus.o_fwd_en), 64'd0);
        check("t6.rst_cnt", 64'(bus.o_stall_cycles), 64'd0);
        check("t6.rst_data", 64'(bus.o_data), 64'd0);
        check("t6.rst_stall", 64'(bus.o_stall), 64'd1);
        @(negedge clk);
        cycle("t6inrst");
        rst_n = 1'b1;
        cycle("t6post");

        // Random traffic over a small register window
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < NO; j++) begin
                rs[j] = $urandom_range(0, 3);
                use_op[j] = $urandom_range(0, 3) != 0;
            end
            for (int k = 0; k < NS; k++) begin
                we[k]  = $urandom_range(0, 1);
                rd[k]  = $urandom_range(0, 3);
                rdy[k] = $urandom_range(0, 9) < 7;
                dat[k] = $urandom;
            end
            valid = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 9) == 0;
            clr   = $urandom_range(0, 19) == 0;
            cycle("rnd");
        end

        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d left required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
